// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : one-at-a-time request -> external ALU -> held result sequencer
// Revision: 1.0
// ============================================================================
module alu_sequencer #(
  parameter int SIZE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_command,
  input  logic [SIZE-1:0]     in_a,
  input  logic [SIZE-1:0]     in_b,
  output logic                alu_enable,
  output logic [3:0]          alu_command,
  output logic [SIZE-1:0]     alu_a,
  output logic [SIZE-1:0]     alu_b,
  input  logic                alu_overflow,
  input  logic [2*SIZE-1:0]   alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*SIZE-1:0]   out_result,
  output logic                out_overflow,
  output logic                out_illegal,
  output logic                sticky_overflow,
  input  logic                clear_sticky,
  output logic [7:0]          op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          cmd_q;
  logic [SIZE-1:0]     a_q;
  logic [SIZE-1:0]     b_q;
  logic [2*SIZE-1:0]   result_q;
  logic                ovf_q;
  logic                illegal_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                alu_en_q;
  logic                sticky_q;
  logic                sticky_d;
  logic [7:0]          count_q;
  logic [7:0]          count_d;
  logic                handshake;
  logic                cmd_illegal;

  // Opcodes 12..15 have both top bits set.
  assign cmd_illegal = cmd_q[3] & cmd_q[2];
  assign handshake   = out_valid_q & out_ready;

  // A delivering overflow takes priority over a coincident clear.
  always_comb begin
    sticky_d = sticky_q;
    if (handshake && ovf_q) begin
      sticky_d = 1'b1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end
    count_d = count_q + {7'd0, handshake};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_en_q    <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= EXEC;
            cmd_q      <= in_command;
            a_q        <= in_a;
            b_q        <= in_b;
            in_ready_q <= 1'b0;
            alu_en_q   <= ~(in_command[3] & in_command[2]);
          end
        end
        EXEC: begin
          state_q     <= HOLD;
          alu_en_q    <= 1'b0;
          out_valid_q <= 1'b1;
          illegal_q   <= cmd_illegal;
          result_q    <= cmd_illegal ? '0 : alu_result;
          ovf_q       <= cmd_illegal ? 1'b0 : alu_overflow;
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          alu_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign alu_enable      = alu_en_q;
  assign alu_command     = cmd_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign out_result      = result_q;
  assign out_overflow    = ovf_q;
  assign out_illegal     = illegal_q;
  assign sticky_overflow = sticky_q;
  assign op_count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : randomized transaction-level check of alu_sequencer
// Revision: 1.0
// ============================================================================
module tb_alu_sequencer;
  localparam int SIZE = 2;
  localparam int W    = 2 * SIZE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_command = 4'd0;
  logic [SIZE-1:0] in_a = '0;
  logic [SIZE-1:0] in_b = '0;
  logic            alu_enable;
  logic [3:0]      alu_command;
  logic [SIZE-1:0] alu_a;
  logic [SIZE-1:0] alu_b;
  logic            alu_overflow;
  logic [W-1:0]    alu_result;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_result;
  logic            out_overflow;
  logic            out_illegal;
  logic            sticky_overflow;
  logic            clear_sticky = 1'b0;
  logic [7:0]      op_count;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference state
  logic [7:0] m_count  = 8'd0;
  logic       m_sticky = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.SIZE(SIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_command     (in_command),
    .in_a           (in_a),
    .in_b           (in_b),
    .alu_enable     (alu_enable),
    .alu_command    (alu_command),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_overflow   (alu_overflow),
    .alu_result     (alu_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_overflow   (out_overflow),
    .out_illegal    (out_illegal),
    .sticky_overflow(sticky_overflow),
    .clear_sticky   (clear_sticky),
    .op_count       (op_count)
  );

  // Behavioural ALU; opcodes 12..15 return garbage that the sequencer must mask.
  function automatic logic [W:0] alu_ref(input logic [3:0] c, input logic [SIZE-1:0] a,
                                         input logic [SIZE-1:0] b);
    logic [31:0] ai, bi, r;
    logic        o;
    ai = 32'(a);
    bi = 32'(b);
    o  = 1'b0;
    case (c)
      4'd0:  r = ai;
      4'd1:  r = bi;
      4'd2:  r = ai & bi;
      4'd3:  r = ai | bi;
      4'd4:  begin r = ai + bi; o = (r >= (32'd1 << SIZE)); end
      4'd5:  r = ai * bi;
      4'd6:  begin r = ai - bi; o = (ai < bi); end
      4'd7:  r = ai ^ bi;
      4'd8:  r = (~ai) & ((32'd1 << SIZE) - 32'd1);
      4'd9:  r = ai << 1;
      4'd10: r = (ai << SIZE) | bi;
      4'd11: r = {31'd0, ai == bi};
      default: begin r = 32'hFFFF_FFFF; o = 1'b1; end
    endcase
    return {o, r[W-1:0]};
  endfunction

  assign {alu_overflow, alu_result} = alu_ref(alu_command, alu_a, alu_b);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_tick(input logic clr);
    in_valid     = 1'b0;
    clear_sticky = clr;
    @(posedge clk);
    if (clr) m_sticky = 1'b0;
    @(negedge clk);
    clear_sticky = 1'b0;
    check_val("idle_sticky", 32'(sticky_overflow), 32'(m_sticky));
    check_val("idle_in_ready", 32'(in_ready), 32'd1);
    check_val("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  // One full transaction: accept, EXEC, HOLD for 'hold' stalled cycles, handshake.
  task automatic send_op(input logic [3:0] cmd, input logic [SIZE-1:0] a,
                         input logic [SIZE-1:0] b, input int hold, input logic hs_clr);
    logic [W:0]   r;
    logic         ill, exp_ovf, clr;
    logic [W-1:0] exp_res;
    int           waited;
    r       = alu_ref(cmd, a, b);
    ill     = (cmd >= 4'd12);
    exp_res = ill ? '0 : r[W-1:0];
    exp_ovf = ill ? 1'b0 : r[W];
    waited  = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_val("accept_ready", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_command = cmd;
    in_a       = a;
    in_b       = b;
    out_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("exec_in_ready", 32'(in_ready), 32'd0);
    check_val("exec_out_valid", 32'(out_valid), 32'd0);
    check_val("exec_alu_enable", 32'(alu_enable), 32'(!ill));
    check_val("exec_alu_cmd", 32'(alu_command), 32'(cmd));
    check_val("exec_alu_ab", 32'({alu_a, alu_b}), 32'({a, b}));
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      check_val("hold_out_valid", 32'(out_valid), 32'd1);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
      check_val("hold_alu_enable", 32'(alu_enable), 32'd0);
      check_val("hold_result", 32'(out_result), 32'(exp_res));
      check_val("hold_overflow", 32'(out_overflow), 32'(exp_ovf));
      check_val("hold_illegal", 32'(out_illegal), 32'(ill));
      check_val("hold_sticky", 32'(sticky_overflow), 32'(m_sticky));
      check_val("hold_count", 32'(op_count), 32'(m_count));
      if (i == hold) break;
      in_valid     = 1'($urandom_range(0, 1));
      in_command   = 4'($urandom);
      in_a         = SIZE'($urandom);
      in_b         = SIZE'($urandom);
      clr          = ($urandom_range(0, 3) == 0);
      clear_sticky = clr;
      @(posedge clk);
      if (clr) m_sticky = 1'b0;
      @(negedge clk);
      in_valid     = 1'b0;
      clear_sticky = 1'b0;
    end
    out_ready    = 1'b1;
    clear_sticky = hs_clr;
    @(posedge clk);
    m_sticky = exp_ovf ? 1'b1 : (hs_clr ? 1'b0 : m_sticky);
    m_count  = m_count + 8'd1;
    @(negedge clk);
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
    check_val("post_out_valid", 32'(out_valid), 32'd0);
    check_val("post_in_ready", 32'(in_ready), 32'd1);
    check_val("post_count", 32'(op_count), 32'(m_count));
    check_val("post_sticky", 32'(sticky_overflow), 32'(m_sticky));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_alu_enable", 32'(alu_enable), 32'd0);
    check_val("rst_outputs", 32'({out_result, out_overflow, out_illegal, sticky_overflow}), 32'd0);
    check_val("rst_count", 32'(op_count), 32'd0);
    check_val("rst_operands", 32'({alu_command, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed: add with overflow, stalled pass-through, illegal opcode
    send_op(4'd4, 2'd3, 2'd3, 0, 1'b0);
    check_val("add_result", 32'(out_result), 32'd6);
    send_op(4'd0, 2'd2, 2'd3, 5, 1'b0);
    send_op(4'd13, 2'd1, 2'd2, 2, 1'b0);
    // Overflow delivery coincident with clear: set wins, then clear
    idle_tick(1'b1);
    send_op(4'd4, 2'd3, 2'd2, 0, 1'b1);
    check_val("set_wins", 32'(sticky_overflow), 32'd1);
    idle_tick(1'b1);
    check_val("clear_after", 32'(sticky_overflow), 32'd0);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      send_op(4'($urandom), SIZE'($urandom), SIZE'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_tick(1'($urandom_range(0, 1)));
    end

    // Reset asserted while a result is held
    in_valid   = 1'b1;
    in_command = 4'd5;
    in_a       = 2'd3;
    in_b       = 2'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    m_count  = 8'd0;
    m_sticky = 1'b0;
    check_val("rst_hold_valid", 32'(out_valid), 32'd0);
    check_val("rst_hold_ready", 32'(in_ready), 32'd1);
    check_val("rst_hold_count", 32'(op_count), 32'(m_count));
    check_val("rst_hold_result", 32'(out_result), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check_val("rst_no_hs", 32'(op_count), 32'd0);

    // 256 deliveries wrap the counter back to zero
    for (int k = 0; k < 256; k++) begin
      send_op(4'($urandom), SIZE'($urandom), SIZE'($urandom), 0, 1'b0);
    end
    check_val("count_wrap", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter SIZE, default 2, the operand width in bits; results are 2*SIZE bits.
REQ-002 The block SHALL have clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst, input, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have in_valid, input, 1 bit, meaning an operation request is present.
REQ-005 The block SHALL have in_ready, output, 1 bit, meaning a request is accepted this cycle.
REQ-006 The block SHALL have in_command, input, 4 bits, the ALU opcode.
REQ-007 The block SHALL have in_a and in_b, inputs, SIZE bits each, the operands.
REQ-008 The block SHALL have alu_enable, output, 1 bit, driving the ALU enable.
REQ-009 The block SHALL have alu_command, output, 4 bits, driving the ALU command.
REQ-010 The block SHALL have alu_a and alu_b, outputs, SIZE bits each, driving the ALU operands.
REQ-011 The block SHALL have alu_overflow, input, 1 bit, the ALU overflow result.
REQ-012 The block SHALL have alu_result, input, 2*SIZE bits, the ALU result.
REQ-013 The block SHALL have out_valid, output, 1 bit, meaning a result is held.
REQ-014 The block SHALL have out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-015 The block SHALL have out_result, output, 2*SIZE bits, the registered result.
REQ-016 The block SHALL have out_overflow, output, 1 bit, the registered overflow.
REQ-017 The block SHALL have out_illegal, output, 1 bit, meaning the opcode was 12..15.
REQ-018 The block SHALL have sticky_overflow, output, 1 bit, set by any delivered overflow.
REQ-019 The block SHALL have clear_sticky, input, 1 bit, a synchronous clear of sticky_overflow.
REQ-020 The block SHALL have op_count, output, 8 bits, counting delivered results.

Function
REQ-021 The block SHALL use FSM states IDLE, EXEC and HOLD.
REQ-022 In IDLE, in_ready=1; on in_valid=1 it SHALL latch in_command/in_a/in_b into operand registers and go to EXEC; otherwise it stays in IDLE.
REQ-023 in_ready SHALL be 0 in EXEC and HOLD; requests presented then are not accepted.
REQ-024 alu_command/alu_a/alu_b SHALL always drive the operand registers; alu_enable SHALL be 1 only in EXEC and only when the latched opcode is 0..11.
REQ-025 In EXEC the block SHALL capture alu_result/alu_overflow into out_result/out_overflow, set out_illegal=0, and go to HOLD (accept-to-out_valid latency exactly 2 cycles).
REQ-026 For a latched opcode 12..15, EXEC SHALL capture out_result=0, out_overflow=0, out_illegal=1.
REQ-027 out_valid SHALL be 1 exactly in HOLD; out_result/out_overflow/out_illegal SHALL remain stable while out_valid=1.
REQ-028 In HOLD with out_ready=1 the block SHALL go to IDLE and increment op_count modulo 256 (255 wraps to 0); with out_ready=0 it stays in HOLD.
REQ-029 On a HOLD handshake with out_overflow=1, sticky_overflow SHALL become 1.
REQ-030 clear_sticky=1 SHALL clear sticky_overflow; if it coincides with a setting handshake, set wins.
REQ-031 Throughput SHALL be at most one operation per 3 cycles; no operations are buffered.

Reset
REQ-032 While rst=1 the FSM SHALL be IDLE with operand registers, out_result, out_overflow, out_illegal, sticky_overflow and op_count at 0; outputs SHALL be in_ready=1, out_valid=0, alu_enable=0.
REQ-033 A reset asserted in EXEC or HOLD SHALL abandon the operation without delivering it and without changing op_count after the reset value.

Verification
REQ-034 SIZE=2, send cmd=4, a=3, b=3; out_ready=1 -> out_valid high 2 cycles after accept, out_result=6, out_overflow per ALU, op_count=1.
REQ-035 Send cmd=0, a=2, b=3 with out_ready=0 for 5 cycles -> out_valid stays 1, out_result=2 stable, in_ready=0, a second in_valid is ignored.
REQ-036 Send cmd=13 -> alu_enable never 1, out_result=0, out_illegal=1, out_overflow=0.
REQ-037 Deliver a result with alu_overflow=1 while clear_sticky=1 in the same cycle -> sticky_overflow=1; clear_sticky next cycle -> sticky_overflow=0.
REQ-038 Deliver 256 results -> op_count reads 0 after the last handshake.
REQ-039 Assert rst during HOLD -> out_valid=0 and in_ready=1 immediately, with no handshake counted.
